// File: rtl/seven_segment_loop_monitor_if.sv
// Segment bus under observation plus the monitor's decoded status.
// master drives samples; slave (the monitor) reports status.
interface seven_segment_loop_monitor_if #(
    parameter int SEG_W = 7,
    parameter int CNT_W = 8
);
    logic             sample_en;
    logic [SEG_W-1:0] seg_in;
    logic             clr;
    logic [2:0]       seg_index;
    logic             index_valid;
    logic             locked;
    logic [CNT_W-1:0] loop_count;
    logic             error;
    logic [1:0]       error_code;
    logic [CNT_W-1:0] error_count;

    modport master (
        output sample_en, seg_in, clr,
        input  seg_index, index_valid, locked, loop_count,
        input  error, error_code, error_count
    );

    modport slave (
        input  sample_en, seg_in, clr,
        output seg_index, index_valid, locked, loop_count,
        output error, error_code, error_count
    );
endinterface

// File: rtl/seven_segment_loop_monitor.sv
// Tracks a rotating one-hot segment pattern, counts loops and
// flags multi-hot, out-of-order and illegal blank samples.
module seven_segment_loop_monitor #(
    parameter int SEG_W       = 7,
    parameter int CNT_W       = 8,
    parameter bit ALLOW_BLANK = 1'b1
) (
    input  logic clk,
    input  logic rst,
    seven_segment_loop_monitor_if.slave bus
);

    localparam int OW = $clog2(SEG_W + 1);
    localparam logic [2:0] LAST = 3'(SEG_W - 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        GAP      = 2'd2
    } state_t;

    state_t     state, nxt_state;
    logic [2:0] expected, nxt_exp;
    logic [OW-1:0] ones;
    logic [2:0] idx;
    logic       onehot, blank, multi;
    logic       acc, err, loop_inc;
    logic [1:0] err_code;

    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < SEG_W; i++) begin
            if (bus.seg_in[i]) begin
                ones = ones + OW'(1);
                idx  = 3'(i);
            end
        end
        onehot = (ones == OW'(1));
        blank  = (ones == '0);
        multi  = !onehot && !blank;
    end

    always_comb begin
        nxt_state = state;
        nxt_exp   = expected;
        acc       = 1'b0;
        err       = 1'b0;
        err_code  = 2'b00;
        loop_inc  = 1'b0;
        unique case (state)
            UNLOCKED: begin
                unique case (1'b1)
                    onehot: begin
                        acc = 1'b1;
                        if (idx == 3'd0) begin
                            nxt_state = LOCKED;
                            nxt_exp   = 3'd1;
                        end
                    end
                    blank: ;
                    multi: begin
                        err      = 1'b1;
                        err_code = 2'b01;
                    end
                endcase
            end
            LOCKED: begin
                unique case (1'b1)
                    onehot: begin
                        if (idx == expected) begin
                            acc      = 1'b1;
                            nxt_exp  = (expected == LAST) ? 3'd0 : expected + 3'd1;
                            loop_inc = (idx == LAST);
                        end else begin
                            err      = 1'b1;
                            err_code = 2'b10;
                            // a stray 0 restarts the rotation immediately
                            if (idx == 3'd0) begin
                                acc     = 1'b1;
                                nxt_exp = 3'd1;
                            end else begin
                                nxt_state = UNLOCKED;
                                nxt_exp   = 3'd0;
                            end
                        end
                    end
                    blank: begin
                        if (ALLOW_BLANK && expected == 3'd0) begin
                            nxt_state = GAP;
                        end else begin
                            err       = 1'b1;
                            err_code  = 2'b11;
                            nxt_state = UNLOCKED;
                            nxt_exp   = 3'd0;
                        end
                    end
                    multi: begin
                        err       = 1'b1;
                        err_code  = 2'b01;
                        nxt_state = UNLOCKED;
                        nxt_exp   = 3'd0;
                    end
                endcase
            end
            GAP: begin
                nxt_state = UNLOCKED;
                nxt_exp   = 3'd0;
                err       = 1'b1;
                unique case (1'b1)
                    onehot: begin
                        if (idx == 3'd0) begin
                            acc       = 1'b1;
                            err       = 1'b0;
                            nxt_state = LOCKED;
                            nxt_exp   = 3'd1;
                        end else begin
                            err_code = 2'b10;
                        end
                    end
                    blank: err_code = 2'b11;
                    multi: err_code = 2'b01;
                endcase
            end
            default: begin
                nxt_state = UNLOCKED;
                nxt_exp   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= UNLOCKED;
            expected        <= 3'd0;
            bus.seg_index   <= '0;
            bus.index_valid <= 1'b0;
            bus.locked      <= 1'b0;
            bus.error       <= 1'b0;
            bus.error_code  <= 2'b00;
        end else begin
            bus.index_valid <= 1'b0;
            bus.error       <= 1'b0;
            if (bus.sample_en) begin
                state      <= nxt_state;
                expected   <= nxt_exp;
                bus.locked <= (nxt_state != UNLOCKED);
                if (acc) begin
                    bus.seg_index   <= idx;
                    bus.index_valid <= 1'b1;
                end
                if (err) begin
                    bus.error      <= 1'b1;
                    bus.error_code <= err_code;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.loop_count  <= '0;
            bus.error_count <= '0;
        end else if (bus.clr) begin
            bus.loop_count  <= '0;
            bus.error_count <= '0;
        end else if (bus.sample_en) begin
            if (loop_inc && !(&bus.loop_count))
                bus.loop_count <= bus.loop_count + CNT_W'(1);
            if (err && !(&bus.error_count))
                bus.error_count <= bus.error_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seven_segment_loop_monitor.sv
// Directed bench: one stimulus stream drives three monitors
// (default, no-blank-gap, 2-bit counters).
module tb_seven_segment_loop_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic       clr = 1'b0;
    logic [6:0] seg = '0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    seven_segment_loop_monitor_if #(.SEG_W(7), .CNT_W(8)) if_a ();
    seven_segment_loop_monitor_if #(.SEG_W(7), .CNT_W(8)) if_b ();
    seven_segment_loop_monitor_if #(.SEG_W(7), .CNT_W(2)) if_c ();

    assign if_a.sample_en = sample_en;
    assign if_a.seg_in    = seg;
    assign if_a.clr       = clr;
    assign if_b.sample_en = sample_en;
    assign if_b.seg_in    = seg;
    assign if_b.clr       = clr;
    assign if_c.sample_en = sample_en;
    assign if_c.seg_in    = seg;
    assign if_c.clr       = clr;

    seven_segment_loop_monitor #(.SEG_W(7), .CNT_W(8), .ALLOW_BLANK(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    seven_segment_loop_monitor #(.SEG_W(7), .CNT_W(8), .ALLOW_BLANK(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    seven_segment_loop_monitor #(.SEG_W(7), .CNT_W(2), .ALLOW_BLANK(1'b1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply(input logic en, input logic [6:0] s, input logic c);
        @(negedge clk);
        sample_en = en;
        seg       = s;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic c = 1'b0);
        logic [6:0] v;
        v    = '0;
        v[i] = 1'b1;
        apply(1'b1, v, c);
    endtask

    task automatic run_loop();
        for (int i = 0; i < 7; i++) put(i);
    endtask

    task automatic do_reset();
        sample_en = 1'b0;
        seg       = '0;
        clr       = 1'b0;
        rst       = 1'b0;
        #2;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst seg_index", int'(if_a.seg_index), 0);
        chk("rst index_valid", int'(if_a.index_valid), 0);
        chk("rst locked", int'(if_a.locked), 0);
        chk("rst loop_count", int'(if_a.loop_count), 0);
        chk("rst error", int'(if_a.error), 0);
        chk("rst error_code", int'(if_a.error_code), 0);
        chk("rst error_count", int'(if_a.error_count), 0);

        // two clean loops
        put(0);
        chk("lock after 0", int'(if_a.locked), 1);
        chk("iv after 0", int'(if_a.index_valid), 1);
        for (int i = 1; i < 7; i++) begin
            put(i);
            chk("seg_index loop1", int'(if_a.seg_index), i);
        end
        run_loop();
        chk("loop_count 2", int'(if_a.loop_count), 2);
        chk("err_count clean", int'(if_a.error_count), 0);

        // loop, blank gap, loop
        do_reset();
        run_loop();
        apply(1'b1, 7'b0, 1'b0);
        chk("gap a error", int'(if_a.error), 0);
        chk("gap a locked", int'(if_a.locked), 1);
        chk("gap b error", int'(if_b.error), 1);
        chk("gap b code", int'(if_b.error_code), 3);
        chk("gap b locked", int'(if_b.locked), 0);
        put(0);
        chk("gap a relock", int'(if_a.locked), 1);
        chk("gap b relock", int'(if_b.locked), 1);
        for (int i = 1; i < 7; i++) put(i);
        chk("gap a loops", int'(if_a.loop_count), 2);
        chk("gap a errs", int'(if_a.error_count), 0);
        chk("gap b loops", int'(if_b.loop_count), 2);
        chk("gap b errs", int'(if_b.error_count), 1);

        // skip and relock-on-0
        do_reset();
        put(0); put(1); put(2); put(4);
        chk("skip error", int'(if_a.error), 1);
        chk("skip code", int'(if_a.error_code), 2);
        chk("skip locked", int'(if_a.locked), 0);
        chk("skip errcnt", int'(if_a.error_count), 1);
        put(0);
        chk("relock", int'(if_a.locked), 1);
        chk("relock no err", int'(if_a.error), 0);
        put(1);
        put(0);
        chk("r0 error", int'(if_a.error), 1);
        chk("r0 iv", int'(if_a.index_valid), 1);
        chk("r0 seg_index", int'(if_a.seg_index), 0);
        chk("r0 locked", int'(if_a.locked), 1);
        chk("r0 errcnt", int'(if_a.error_count), 2);

        // multi-hot while locked, then double blank
        apply(1'b1, 7'b0000011, 1'b0);
        chk("multi error", int'(if_a.error), 1);
        chk("multi code", int'(if_a.error_code), 1);
        chk("multi locked", int'(if_a.locked), 0);
        run_loop();
        apply(1'b1, 7'b0, 1'b0);
        chk("blank1 error", int'(if_a.error), 0);
        apply(1'b1, 7'b0, 1'b0);
        chk("blank2 error", int'(if_a.error), 1);
        chk("blank2 code", int'(if_a.error_code), 3);
        chk("blank2 locked", int'(if_a.locked), 0);
        chk("blank2 errcnt", int'(if_a.error_count), 4);

        // sample_en low holds everything
        do_reset();
        put(0); put(1); put(2);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 7'b1010101, 1'b0);
            chk("hold iv", int'(if_a.index_valid), 0);
            chk("hold error", int'(if_a.error), 0);
            chk("hold idx", int'(if_a.seg_index), 2);
            chk("hold locked", int'(if_a.locked), 1);
        end
        put(3);
        chk("resume idx", int'(if_a.seg_index), 3);
        chk("resume error", int'(if_a.error), 0);

        // saturation at CNT_W=2, then clr wins over increment
        do_reset();
        for (int l = 0; l < 5; l++) run_loop();
        chk("sat c loops", int'(if_c.loop_count), 3);
        chk("a loops 5", int'(if_a.loop_count), 5);
        for (int i = 0; i < 6; i++) put(i);
        put(6, 1'b1);
        chk("clr c loops", int'(if_c.loop_count), 0);
        chk("clr a loops", int'(if_a.loop_count), 0);
        chk("clr keeps lock", int'(if_a.locked), 1);

        // asynchronous reset mid-cycle
        do_reset();
        put(0); put(1); put(2); put(3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst idx", int'(if_a.seg_index), 0);
        chk("arst locked", int'(if_a.locked), 0);
        chk("arst iv", int'(if_a.index_valid), 0);
        chk("arst loops", int'(if_a.loop_count), 0);
        @(negedge clk);
        rst = 1'b1;
        put(4);
        chk("post 4 locked", int'(if_a.locked), 0);
        chk("post 4 idx", int'(if_a.seg_index), 4);
        put(0);
        chk("post 0 locked", int'(if_a.locked), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
